// File: rtl/inv_key_stream_if.sv
// rtl/inv_key_stream_if.sv - round key stream handshake between key source and decrypt consumer
interface inv_key_stream_if;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;

  modport master (
    output rk_out,
    output rk_idx,
    output rk_valid,
    input  rk_ready
  );

  modport slave (
    input  rk_out,
    input  rk_idx,
    input  rk_valid,
    output rk_ready
  );
endinterface

// File: rtl/inv_key_stream.sv
// rtl/inv_key_stream.sv - AES-128 round keys in decrypt order via forward expansion then inverse walk

// Forward AES S-box built from the GF(2^8) inverse (x^254) plus the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] v);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = v;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = gf_inv(a);
    y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end
endmodule

module inv_key_stream #(
  parameter int NR = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [127:0]           key_in,
  input  logic                   key_load,
  input  logic                   restart,
  inv_key_stream_if.master       rk_if,
  output logic                   busy,
  output logic                   cache_valid
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [3:0] LAST     = 4'(NR);

  logic [1:0]   state;
  logic [127:0] work;
  logic [127:0] cache;
  logic [127:0] rk_q;
  logic [3:0]   idx_q;
  logic [3:0]   round;
  logic         valid_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  a0, a1, a2, a3;
  logic [31:0]  inv_b3;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [3:0]   rcon_sel;
  logic [31:0]  rcon_w;
  logic [127:0] fwd_key;
  logic [127:0] inv_key;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign {w0, w1, w2, w3} = work;
  assign {a0, a1, a2, a3} = rk_q;
  assign inv_b3 = a3 ^ a2;

  // One S-box bank serves both directions: forward uses w3, inverse uses the rebuilt b3.
  always_comb begin
    sub_in   = 32'h0;
    rcon_sel = 4'd0;
    if (state == S_STREAM) begin
      sub_in   = {inv_b3[23:0], inv_b3[31:24]};
      rcon_sel = idx_q;
    end else begin
      sub_in   = {w3[23:0], w3[31:24]};
      rcon_sel = round;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*g +: 8]),
      .y (sub_out[8*g +: 8])
    );
  end

  assign rcon_w = {rcon(rcon_sel), 24'h000000};

  always_comb begin
    logic [31:0] f0, f1, f2, f3;
    f0      = w0 ^ sub_out ^ rcon_w;
    f1      = w1 ^ f0;
    f2      = w2 ^ f1;
    f3      = w3 ^ f2;
    fwd_key = {f0, f1, f2, f3};
  end

  assign inv_key = {a0 ^ sub_out ^ rcon_w, a1 ^ a0, a2 ^ a1, inv_b3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      work        <= '0;
      cache       <= '0;
      rk_q        <= '0;
      idx_q       <= '0;
      round       <= '0;
      valid_q     <= 1'b0;
      busy        <= 1'b0;
      cache_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_load) begin
            work        <= key_in;
            round       <= 4'd1;
            cache_valid <= 1'b0;
            busy        <= 1'b1;
            state       <= S_EXPAND;
          end else if (restart && cache_valid) begin
            rk_q    <= cache;
            idx_q   <= LAST;
            valid_q <= 1'b1;
            busy    <= 1'b1;
            state   <= S_STREAM;
          end
        end
        S_EXPAND: begin
          work  <= fwd_key;
          round <= round + 4'd1;
          if (round == LAST) begin
            cache       <= fwd_key;
            cache_valid <= 1'b1;
            rk_q        <= fwd_key;
            idx_q       <= LAST;
            valid_q     <= 1'b1;
            state       <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (valid_q && rk_if.rk_ready) begin
            if (idx_q == 4'd0) begin
              valid_q <= 1'b0;
              busy    <= 1'b0;
              state   <= S_IDLE;
            end else begin
              rk_q  <= inv_key;
              idx_q <= idx_q - 4'd1;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign rk_if.rk_out   = rk_q;
  assign rk_if.rk_idx   = idx_q;
  assign rk_if.rk_valid = valid_q;
endmodule
